// File: rtl/romload_sink.sv
// ---------------------------------------------------------------------------
// romload_sink
//
// Receiving end of the iosys ROM-loading byte stream. Incoming bytes are
// paired into little-endian 16-bit words, buffered in a small word FIFO and
// written sequentially into SDRAM through a write-only request/wait port.
// The first HDR_BYTES payload bytes are also captured into a small header
// buffer so the mapper-detect logic can inspect the SNES header window.
//
// Optional feature (compile-time macro ROMLOAD_COPIER_STRIP_EN):
//   when defined and copier_strip=1 at load start, the first 512 stream bytes
//   (copier header) are discarded and payload byte 0 is stream byte 512.
//   When undefined, copier_strip is ignored and every stream byte is payload.
//
// Parameters:
//   BASE_ADDR   SDRAM byte address of ROM byte 0 (even)
//   FIFO_DEPTH  word FIFO entries (power of 2, >= 2); the word currently
//               presented on the SDRAM port still occupies its entry
//   HDR_BYTES   leading payload bytes captured into the header buffer
//
// Ports:
//   clk, reset          sole clock, synchronous active-high reset
//   rom_loading         level; rising edge starts a load, falling edge ends it
//   rom_do/rom_do_valid stream byte and its strobe
//   copier_strip        copier-header strip request, sampled at load start
//   mem_addr/din/ds/wr  SDRAM write request (held until accepted)
//   mem_wait            SDRAM busy; accept = mem_wr & ~mem_wait
//   hdr_raddr/hdr_rdata header buffer read port, 1-cycle latency
//   rom_size            payload bytes received in the current/last load
//   busy/done/overflow  load status; done pulses once, overflow is sticky
// ---------------------------------------------------------------------------
module romload_sink #(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          HDR_BYTES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  input  logic        copier_strip,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_wr,
  input  logic        mem_wait,
  input  logic [5:0]  hdr_raddr,
  output logic [7:0]  hdr_rdata,
  output logic [23:0] rom_size,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HDR_AW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  localparam logic [22:0]      BASE_EVEN = {BASE_ADDR[22:1], 1'b0};
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [23:0]      HDR_LIMIT = 24'(HDR_BYTES);
  localparam logic [23:0]      SIZE_MAX  = 24'hFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              loading_q, loading_d;
  logic [23:0]       rom_size_q, rom_size_d;
  logic [7:0]        low_byte_q, low_byte_d;
  logic              low_valid_q, low_valid_d;
  logic              overflow_q, overflow_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [1:0]        mem_ds_q, mem_ds_d;
  logic [22:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        hdr_rdata_q;

  // FIFO entry = {ds[1:0], data[15:0]}
  logic [17:0]       fifo_mem [FIFO_DEPTH];
  logic [7:0]        hdr_mem  [HDR_BYTES];

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic              start;
  logic              fall;
  logic              accept;
  logic              byte_in;
  logic              payload_in;
  logic              skipping;
  logic              push_req;
  logic              push_ok;
  logic [17:0]       push_word;
  logic              fifo_we;
  logic              hdr_we;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [HDR_AW-1:0] hdr_widx;
  logic [HDR_AW-1:0] hdr_ridx;

  // Edges are taken against the registered copy of rom_loading.
  assign start  = rom_loading & ~loading_q;
  assign fall   = ~rom_loading & loading_q;
  assign accept = mem_wr_q & ~mem_wait;

  // loading_q is always 1 while in LOAD, so a byte arriving in the same
  // cycle as the falling edge is still taken; FLUSH then sees it.
  assign byte_in = (state_q == ST_LOAD) & rom_do_valid;

  assign rd_ptr_next = rd_ptr_q + PTR_W'(1);
  assign hdr_widx    = rom_size_q[HDR_AW-1:0];
  assign hdr_ridx    = HDR_AW'(hdr_raddr);

`ifdef ROMLOAD_COPIER_STRIP_EN
  // Remaining copier-header bytes to discard in this load.
  logic [9:0] skip_left_q, skip_left_d;

  assign skipping = (skip_left_q != 10'd0);

  always_comb begin
    skip_left_d = skip_left_q;
    if (byte_in && skipping) begin
      skip_left_d = skip_left_q - 10'd1;
    end
    if (start) begin
      skip_left_d = copier_strip ? 10'd512 : 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_left_q <= 10'd0;
    end else begin
      skip_left_q <= skip_left_d;
    end
  end
`else
  logic unused_copier_strip;
  assign unused_copier_strip = copier_strip;
  assign skipping            = 1'b0;
`endif

  assign payload_in = byte_in & ~skipping;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    loading_d   = rom_loading;
    rom_size_d  = rom_size_q;
    low_byte_d  = low_byte_q;
    low_valid_d = low_valid_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_wr_d    = mem_wr_q;
    mem_din_d   = mem_din_q;
    mem_ds_d    = mem_ds_q;
    mem_addr_d  = mem_addr_q;
    push_req    = 1'b0;
    push_word   = 18'd0;
    push_ok     = 1'b0;
    hdr_we      = 1'b0;
    fifo_we     = 1'b0;

    // Byte intake: even payload index is latched, odd index completes a word.
    if (payload_in) begin
      if (rom_size_q != SIZE_MAX) begin
        rom_size_d = rom_size_q + 24'd1;
      end
      hdr_we = (rom_size_q < HDR_LIMIT);
      if (low_valid_q) begin
        push_req    = 1'b1;
        push_word   = {2'b11, rom_do, low_byte_q};
        low_valid_d = 1'b0;
      end else begin
        low_byte_d  = rom_do;
        low_valid_d = 1'b1;
      end
    end

    // Odd-length load: emit the dangling low byte with only the low lane.
    if ((state_q == ST_FLUSH) && low_valid_q) begin
      push_req    = 1'b1;
      push_word   = {2'b01, 8'h00, low_byte_q};
      low_valid_d = 1'b0;
    end

    // The in-flight word keeps its FIFO slot until accepted, so a push into
    // a full FIFO only succeeds when that word leaves in the same cycle.
    push_ok = push_req && ((count_q != FIFO_FULL) || accept);
    fifo_we = push_ok;
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Write engine.
    if (accept) begin
      rd_ptr_d   = rd_ptr_next;
      mem_addr_d = mem_addr_q + 23'd2;
      if (count_q > CNT_W'(1)) begin
        mem_wr_d              = 1'b1;
        {mem_ds_d, mem_din_d} = fifo_mem[rd_ptr_next];
      end else if (push_ok) begin
        // FIFO drains to just the word being pushed: forward it directly
        // so the port stays back-to-back.
        mem_wr_d              = 1'b1;
        {mem_ds_d, mem_din_d} = push_word;
      end else begin
        mem_wr_d = 1'b0;
      end
    end else if (!mem_wr_q && (count_q != '0)) begin
      mem_wr_d              = 1'b1;
      {mem_ds_d, mem_din_d} = fifo_mem[rd_ptr_q];
    end

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(accept);

    case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        if (fall) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!low_valid_q && (count_q == '0) && !mem_wr_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load start (also a restart while busy): discard everything pending,
    // including any write still waiting on the SDRAM port.
    if (start) begin
      state_d     = ST_LOAD;
      rom_size_d  = 24'd0;
      low_valid_d = 1'b0;
      overflow_d  = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = BASE_EVEN;
      fifo_we     = 1'b0;
      hdr_we      = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      loading_q   <= 1'b0;
      rom_size_q  <= 24'd0;
      low_byte_q  <= 8'd0;
      low_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_din_q   <= 16'd0;
      mem_ds_q    <= 2'b11;
      mem_addr_q  <= BASE_EVEN;
      hdr_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      loading_q   <= loading_d;
      rom_size_q  <= rom_size_d;
      low_byte_q  <= low_byte_d;
      low_valid_q <= low_valid_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_wr_q    <= mem_wr_d;
      mem_din_q   <= mem_din_d;
      mem_ds_q    <= mem_ds_d;
      mem_addr_q  <= mem_addr_d;
      hdr_rdata_q <= hdr_mem[hdr_ridx];
    end
  end

  // Storage arrays carry no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (!reset && fifo_we) begin
      fifo_mem[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && hdr_we) begin
      hdr_mem[hdr_widx] <= rom_do;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_ds    = mem_ds_q;
  assign mem_wr    = mem_wr_q;
  assign hdr_rdata = hdr_rdata_q;
  assign rom_size  = rom_size_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_romload_sink.sv
// ---------------------------------------------------------------------------
// tb_romload_sink
//
// Directed + randomized bench for romload_sink. Expected SDRAM writes are
// derived from the payload byte list (pairs of bytes, little-endian, padded
// last word) and compared against the writes observed on the memory port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_romload_sink;

  localparam logic [22:0] BASE  = 23'h000000;
  localparam int          DEPTH = 8;
`ifdef ROMLOAD_COPIER_STRIP_EN
  localparam bit STRIP_DEF = 1'b1;
`else
  localparam bit STRIP_DEF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_loading = 1'b0;
  logic [7:0]  rom_do = 8'd0;
  logic        rom_do_valid = 1'b0;
  logic        copier_strip = 1'b0;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_wr;
  logic        mem_wait = 1'b0;
  logic [5:0]  hdr_raddr = 6'd0;
  logic [7:0]  hdr_rdata;
  logic [23:0] rom_size;
  logic        busy;
  logic        done;
  logic        overflow;

  romload_sink #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .HDR_BYTES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_loading (rom_loading),
    .rom_do      (rom_do),
    .rom_do_valid(rom_do_valid),
    .copier_strip(copier_strip),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_ds      (mem_ds),
    .mem_wr      (mem_wr),
    .mem_wait    (mem_wait),
    .hdr_raddr   (hdr_raddr),
    .hdr_rdata   (hdr_rdata),
    .rom_size    (rom_size),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } wr_t;

  wr_t        wr_log[$];
  wr_t        exp_q[$];
  wr_t        cur_w;
  wr_t        prev_w = '0;
  logic       prev_hold = 1'b0;
  int         done_cnt = 0;
  int         stab_err = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         wait_mode = 0;   // 0: low, 1: high, 2: random runs of <= 3
  int         wait_run = 0;
  logic [7:0] stream[$];
  logic [7:0] pl[$];
  logic [7:0] hdr_model[64];

  assign cur_w = {mem_addr, mem_ds, mem_din};

  // Port monitor: logs accepted writes, counts done pulses, and flags any
  // change on the request while it is being held off by mem_wait.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && (!mem_wr || (cur_w !== prev_w))) stab_err <= stab_err + 1;
      if (mem_wr && !mem_wait) wr_log.push_back(cur_w);
      if (done) done_cnt <= done_cnt + 1;
      prev_hold <= mem_wr && mem_wait;
      prev_w    <= cur_w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (wait_mode)
      0: mem_wait = 1'b0;
      1: mem_wait = 1'b1;
      default: begin
        if (wait_run >= 3) begin
          mem_wait = 1'b0;
          wait_run = 0;
        end else begin
          mem_wait = ($urandom_range(0, 9) < 4);
          wait_run = mem_wait ? wait_run + 1 : 0;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Payload = stream minus the copier header when stripping is in effect.
  task automatic build_payload(input bit strip);
    int first;
    first = (strip && STRIP_DEF) ? 512 : 0;
    pl.delete();
    for (int i = first; i < stream.size(); i++) pl.push_back(stream[i]);
    for (int i = 0; i < pl.size() && i < 64; i++) hdr_model[i] = pl[i];
  endtask

  // Word i = {pl[2i+1], pl[2i]} at BASE+2i; an odd tail gets a zero high
  // byte and only the low lane enabled.
  task automatic build_exp(input int max_words);
    int  nw;
    wr_t w;
    exp_q.delete();
    nw = (pl.size() + 1) / 2;
    for (int i = 0; i < nw && i < max_words; i++) begin
      w.addr = BASE + 23'(2 * i);
      if (2 * i + 1 < pl.size()) begin
        w.ds  = 2'b11;
        w.din = {pl[2 * i + 1], pl[2 * i]};
      end else begin
        w.ds  = 2'b01;
        w.din = {8'h00, pl[2 * i]};
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic begin_load(input bit strip);
    wr_log.delete();
    copier_strip = strip;
    rom_loading  = 1'b1;
    tick();
    copier_strip = 1'b0;
  endtask

  // Bytes in bursts (fixed or random length up to max_burst), gap idle cycles between.
  task automatic feed(input int max_burst, input int gap, input bit rnd);
    int b;
    int blen;
    b    = 0;
    blen = rnd ? $urandom_range(1, max_burst) : max_burst;
    foreach (stream[i]) begin
      rom_do       = stream[i];
      rom_do_valid = 1'b1;
      tick();
      b++;
      if (b == blen) begin
        rom_do_valid = 1'b0;
        repeat (gap) tick();
        b    = 0;
        blen = rnd ? $urandom_range(1, max_burst) : max_burst;
      end
    end
    rom_do_valid = 1'b0;
  endtask

  task automatic end_load();
    rom_loading  = 1'b0;
    rom_do_valid = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic check_load(input string tag, input int d0, input bit exp_ovf);
    int n;
    check({tag, " n_writes"}, 64'(wr_log.size()), 64'(exp_q.size()));
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s wr%0d", tag, i), 64'(wr_log[i]), 64'(exp_q[i]));
    check({tag, " rom_size"}, 64'(rom_size), 64'(pl.size()));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " stable_while_wait"}, 64'(stab_err), 64'd0);
    $display("load %s: bytes=%0d words=%0d rom_size=%0d ovf=%0b", tag, pl.size(),
             wr_log.size(), rom_size, overflow);
  endtask

  task automatic hdr_check(input string tag, input int idx);
    hdr_raddr = 6'(idx);
    tick();
    check($sformatf("%s hdr[%0d]", tag, idx), 64'(hdr_rdata), 64'(hdr_model[idx]));
  endtask

  initial begin
    int d0;
    int len;
    int hlim;

    // ---------------- reset values ----------------
    reset = 1'b1;
    repeat (3) tick();
    check("rst mem_wr", 64'(mem_wr), 64'd0);
    check("rst mem_ds", 64'(mem_ds), 64'd3);
    check("rst mem_addr", 64'(mem_addr), 64'(BASE));
    check("rst mem_din", 64'(mem_din), 64'd0);
    check("rst rom_size", 64'(rom_size), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst hdr_rdata", 64'(hdr_rdata), 64'd0);
    reset = 1'b0;
    tick();

    // ---------------- 8 bytes 00..07 ----------------
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(8'(i));
    build_payload(1'b0);
    build_exp(1 << 20);
    d0 = done_cnt;
    begin_load(1'b0);
    check("t8 busy_during", 64'(busy), 64'd1);
    feed(4, 1, 1'b0);
    end_load();
    wait_done(d0);
    check_load("t8", d0, 1'b0);

    // Bytes while idle are ignored.
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      rom_do = 8'h5A; rom_do_valid = 1'b1; tick();
    end
    rom_do_valid = 1'b0;
    repeat (4) tick();
    check("idle rom_size", 64'(rom_size), 64'd8);
    check("idle writes", 64'(wr_log.size()), 64'd0);

    // ---------------- 5 bytes, odd tail ----------------
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    build_payload(1'b0);
    build_exp(1 << 20);
    d0 = done_cnt;
    begin_load(1'b0);
    feed(4, 1, 1'b0);
    end_load();
    wait_done(d0);
    check_load("t5", d0, 1'b0);

    // ---------------- 16 bytes with mem_wait held high ----------------
    stream.delete();
    for (int i = 0; i < 16; i++) stream.push_back(8'($urandom));
    build_payload(1'b0);
    build_exp(1 << 20);
    d0 = done_cnt;
    wait_mode = 1;
    begin_load(1'b0);
    feed(4, 1, 1'b0);
    wait_mode = 0;
    end_load();
    wait_done(d0);
    check_load("t16w", d0, 1'b0);

    // ---------------- 40 bytes, wait high throughout: overflow ----------------
    stream.delete();
    for (int i = 0; i < 40; i++) stream.push_back(8'(i + 8'h40));
    build_payload(1'b0);
    build_exp(DEPTH);
    d0 = done_cnt;
    wait_mode = 1;
    begin_load(1'b0);
    feed(4, 1, 1'b0);
    repeat (5) tick();
    wait_mode = 0;
    end_load();
    wait_done(d0);
    check_load("t40ovf", d0, 1'b1);

    // ---------------- 100 bytes 0..99, header window ----------------
    stream.delete();
    for (int i = 0; i < 100; i++) stream.push_back(8'(i));
    build_payload(1'b0);
    build_exp(1 << 20);
    d0 = done_cnt;
    begin_load(1'b0);
    feed(4, 1, 1'b0);
    end_load();
    wait_done(d0);
    check_load("t100", d0, 1'b0);
    hdr_check("t100", 63);
    hdr_check("t100", 0);
    hdr_check("t100", 37);

    // ---------------- randomized loads ----------------
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 90);
      stream.delete();
      for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
      build_payload(1'b0);
      build_exp(1 << 20);
      d0 = done_cnt;
      wait_mode = 2;
      begin_load(1'b0);
      feed(4, 6, 1'b1);
      end_load();
      wait_done(d0);
      wait_mode = 0;
      tick();
      check_load($sformatf("rnd%0d", r), d0, 1'b0);
      hlim = (len < 64) ? len : 64;
      hdr_check($sformatf("rnd%0d", r), $urandom_range(0, hlim - 1));
      hdr_check($sformatf("rnd%0d", r), hlim - 1);
    end

    // ---------------- copier header strip request ----------------
    stream.delete();
    if (STRIP_DEF) begin
      for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
      stream.push_back(8'h11); stream.push_back(8'h22);
      stream.push_back(8'h33); stream.push_back(8'h44);
    end else begin
      for (int i = 0; i < 6; i++) stream.push_back(8'(8'h90 + i));
    end
    build_payload(1'b1);
    build_exp(1 << 20);
    d0 = done_cnt;
    begin_load(1'b1);
    feed(4, 1, 1'b0);
    end_load();
    wait_done(d0);
    check_load("strip", d0, 1'b0);
    hdr_check("strip", 0);

    // ---------------- reset mid-load ----------------
    stream.delete();
    for (int i = 0; i < 10; i++) stream.push_back(8'(i + 8'h20));
    d0 = done_cnt;
    wait_mode = 1;
    begin_load(1'b0);
    feed(4, 1, 1'b0);
    check("midrst pending_wr", 64'(mem_wr), 64'd1);
    reset = 1'b1;
    rom_loading = 1'b0;
    tick();
    check("midrst mem_wr", 64'(mem_wr), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst rom_size", 64'(rom_size), 64'd0);
    reset = 1'b0;
    wait_mode = 0;
    repeat (20) tick();
    check("midrst no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst idle_wr", 64'(mem_wr), 64'd0);
    $display("load midrst: reset applied during held write");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
